// File: rtl/fifo_word_packer.sv
// Packs RATIO consecutive entries from a first-word-fall-through fifo into one
// little-endian wide word, presented on a registered valid/ready output with flush support.
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fifo_empty,
    input  logic [DATA_WIDTH-1:0]         fifo_read_data,
    output logic                          fifo_read_en,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*RATIO-1:0]   out_data,
    output logic                          out_partial
);

    localparam int            CW        = $clog2(RATIO);
    localparam int            WW        = DATA_WIDTH * RATIO;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0] cnt_r;
    logic [WW-1:0] acc_r;
    logic [WW-1:0] out_data_r;
    logic          out_valid_r;
    logic          out_partial_r;
    logic          flush_pending_r;

    logic          out_free_s;
    logic          last_lane_s;
    logic          pop_s;
    logic          complete_s;
    logic          flush_req_s;
    logic [CW:0]   eff_cnt_s;
    logic [WW-1:0] acc_next_s;

    // The final lane may only be popped when the completed word has somewhere to go.
    assign out_free_s   = !out_valid_r || out_ready;
    assign last_lane_s  = (cnt_r == LAST_LANE);
    assign pop_s        = reset && !fifo_empty && !flush_pending_r && !(last_lane_s && !out_free_s);
    assign complete_s   = pop_s && last_lane_s;
    assign flush_req_s  = flush || flush_pending_r;
    assign eff_cnt_s    = {1'b0, cnt_r} + {{CW{1'b0}}, pop_s};

    assign fifo_read_en = pop_s;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_partial  = out_partial_r;

    // Accumulator view including the lane popped this cycle.
    always_comb begin
        acc_next_s = acc_r;
        for (int k = 0; k < RATIO; k++) begin
            if (pop_s && (cnt_r == CW'(k))) begin
                acc_next_s[k*DATA_WIDTH +: DATA_WIDTH] = fifo_read_data;
            end else begin
                acc_next_s[k*DATA_WIDTH +: DATA_WIDTH] = acc_r[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Lane counter, accumulator, output register and pending-flush state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r           <= {CW{1'b0}};
            acc_r           <= {WW{1'b0}};
            out_valid_r     <= 1'b0;
            out_data_r      <= {WW{1'b0}};
            out_partial_r   <= 1'b0;
            flush_pending_r <= 1'b0;
        end else if (complete_s) begin
            // A completing pop wins over any flush: the word is full, not partial.
            out_valid_r     <= 1'b1;
            out_data_r      <= acc_next_s;
            out_partial_r   <= 1'b0;
            acc_r           <= {WW{1'b0}};
            cnt_r           <= {CW{1'b0}};
            flush_pending_r <= 1'b0;
        end else if (flush_req_s && (eff_cnt_s != {(CW+1){1'b0}})) begin
            if (out_free_s) begin
                out_valid_r     <= 1'b1;
                out_data_r      <= acc_next_s;
                out_partial_r   <= 1'b1;
                acc_r           <= {WW{1'b0}};
                cnt_r           <= {CW{1'b0}};
                flush_pending_r <= 1'b0;
            end else begin
                acc_r           <= acc_next_s;
                cnt_r           <= eff_cnt_s[CW-1:0];
                flush_pending_r <= 1'b1;
            end
        end else begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            acc_r           <= acc_next_s;
            cnt_r           <= eff_cnt_s[CW-1:0];
            flush_pending_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: queue-based fifo, lane-list reference model
// checked every cycle, plus literal expectations on the accepted word stream.
module tb_fifo_word_packer;

    localparam int DW    = 8;
    localparam int RATIO = 2;
    localparam int WW    = DW * RATIO;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic [DW-1:0] fifo_read_data;
    logic          fifo_read_en;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_data;
    logic          out_partial;

    fifo_word_packer #(.DATA_WIDTH(DW), .RATIO(RATIO)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_read_en   (fifo_read_en),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_partial    (out_partial)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] lanes[$];
    logic [WW:0]   dut_log[$];
    logic [WW:0]   mlog[$];

    logic          mv    = 1'b0;
    logic [WW-1:0] md    = '0;
    logic          mp    = 1'b0;
    logic          mpend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sync_fifo();
        fifo_empty     = (fq.size() == 0);
        fifo_read_data = (fq.size() > 0) ? fq[0] : 8'h00;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        sync_fifo();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [WW-1:0] pack_lanes();
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < lanes.size(); i++) w[i*DW +: DW] = lanes[i];
        return w;
    endfunction

    task automatic check_word(input string name, input int idx, input logic [WW:0] exp);
        checks++;
        if (idx >= dut_log.size()) begin
            errors++;
            $display("FAIL %s: dut word %0d missing (got %0d words) expected %0h", name, idx, dut_log.size(), exp);
        end else if (dut_log[idx] !== exp) begin
            errors++;
            $display("FAIL %s: dut word %0d got %0h expected %0h", name, idx, dut_log[idx], exp);
        end
        checks++;
        if (idx >= mlog.size()) begin
            errors++;
            $display("FAIL %s: model word %0d missing (got %0d words) expected %0h", name, idx, mlog.size(), exp);
        end else if (mlog[idx] !== exp) begin
            errors++;
            $display("FAIL %s: model word %0d got %0h expected %0h", name, idx, mlog[idx], exp);
        end
    endtask

    task automatic clear_logs();
        dut_log.delete();
        mlog.delete();
    endtask

    // Per-cycle compare against the reference model, then advance the model and the fifo.
    initial begin
        logic free;
        logic exp_ren;
        logic do_pop;
        forever begin
            @(negedge clk);
            if (!reset) begin
                lanes.delete();
                mv = 1'b0; md = '0; mp = 1'b0; mpend = 1'b0;
            end
            chk("out_valid", 32'(out_valid), 32'(mv));
            chk("out_data", 32'(out_data), 32'(md));
            chk("out_partial", 32'(out_partial), 32'(mp));
            free    = !mv || out_ready;
            exp_ren = reset && (fq.size() > 0) && !mpend && !((lanes.size() == RATIO - 1) && !free);
            chk("fifo_read_en", 32'(fifo_read_en), 32'(exp_ren));
            if (reset && out_valid && out_ready) dut_log.push_back({out_partial, out_data});
            if (reset) begin
                if (mv && out_ready) mlog.push_back({mp, md});
                if (exp_ren) lanes.push_back(fq[0]);
                if (lanes.size() == RATIO) begin
                    md = pack_lanes(); mv = 1'b1; mp = 1'b0; mpend = 1'b0;
                    lanes.delete();
                end else begin
                    if (mv && out_ready) mv = 1'b0;
                    if ((flush || mpend) && lanes.size() > 0) begin
                        if (free) begin
                            md = pack_lanes(); mv = 1'b1; mp = 1'b1; mpend = 1'b0;
                            lanes.delete();
                        end else begin
                            mpend = 1'b1;
                        end
                    end else begin
                        mpend = 1'b0;
                    end
                end
            end
            do_pop = fifo_read_en;
            @(posedge clk);
            #1;
            if (do_pop && fq.size() > 0) void'(fq.pop_front());
            sync_fifo();
        end
    end

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) fq.push_back(8'(i));
        sync_fifo();

        // Reset with a non-empty fifo: nothing popped.
        cycles(4);
        chk("reset_fifo_kept", 32'(fq.size()), 32'd8);
        reset = 1'b1;

        // Streaming.
        cycles(12);
        check_word("stream0", 0, 17'h00100);
        check_word("stream1", 1, 17'h00302);
        check_word("stream2", 2, 17'h00504);
        check_word("stream3", 3, 17'h00706);
        chk("stream_count", 32'(dut_log.size()), 32'd4);

        // Backpressure.
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(i));
        cycles(12);
        chk("bp_fifo_left", 32'(fq.size()), 32'd5);
        chk("bp_held_data", 32'(out_data), 32'h0100);
        chk("bp_held_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        cycles(12);
        check_word("bp0", 0, 17'h00100);
        check_word("bp1", 1, 17'h00302);
        check_word("bp2", 2, 17'h00504);
        check_word("bp3", 3, 17'h00706);
        chk("bp_count", 32'(dut_log.size()), 32'd4);

        // Flush of a partial word, then a no-op flush.
        clear_logs();
        push(8'hA1); push(8'hB2); push(8'hC3);
        cycles(6);
        chk("flush_fifo_empty", 32'(fq.size()), 32'd0);
        flush = 1'b1; cycles(1); flush = 1'b0;
        cycles(4);
        check_word("flush0", 0, 17'h0B2A1);
        check_word("flush1", 1, 17'h100C3);
        flush = 1'b1; cycles(1); flush = 1'b0;
        cycles(4);
        chk("flush_noop_count", 32'(dut_log.size()), 32'd2);

        // Flush while the output is stalled.
        clear_logs();
        out_ready = 1'b0;
        push(8'h21); push(8'h22);
        cycles(4);
        push(8'h11);
        cycles(3);
        flush = 1'b1; cycles(1); flush = 1'b0;
        push(8'h33); push(8'h44);
        cycles(5);
        chk("stall_fifo_left", 32'(fq.size()), 32'd2);
        chk("stall_held_data", 32'(out_data), 32'h2221);
        out_ready = 1'b1;
        cycles(8);
        check_word("stall0", 0, 17'h02221);
        check_word("stall1", 1, 17'h10011);
        check_word("stall2", 2, 17'h04433);
        chk("stall_count", 32'(dut_log.size()), 32'd3);

        // Reset in the middle of a word.
        clear_logs();
        push(8'h55);
        cycles(3);
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
        push(8'h66); push(8'h77);
        cycles(6);
        check_word("midreset0", 0, 17'h07766);
        chk("midreset_count", 32'(dut_log.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Read-side consumer for the byte-wide first-word-fall-through fifo. It pops DATA_WIDTH-bit entries whenever the fifo is non-empty and assembles RATIO consecutive entries into one wide word, little-endian (the first entry popped goes in the lowest lane). It presents each word on a registered valid/ready output, and a flush input emits a zero-padded partial word. It sits directly downstream of fifo: fifo read_data, empty and read_en connect to fifo_read_data, fifo_empty and fifo_read_en.

Parameters:
DATA_WIDTH, 8, width of one fifo entry (lane).
RATIO, 2, lanes per output word; legal range is 2 or more.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  asynchronous, active-low reset; low clears all state immediately.
fifo_empty  input  1  fifo empty flag.
fifo_read_data  input  DATA_WIDTH  fifo head entry; valid whenever fifo_empty is low (fall-through).
fifo_read_en  output  1  pops the fifo head at the next posedge.
flush  input  1  one-cycle pulse requesting emission of the partially assembled word.
out_valid  output  1  out_data/out_partial hold a word.
out_ready  input  1  consumer accepts the word at posedge when out_valid is high.
out_data  output  DATA_WIDTH*RATIO  assembled word; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
out_partial  output  1  word was produced by flush; unfilled upper lanes are zero.

Behaviour:
- State: lane counter cnt (0..RATIO-1), accumulator acc, output register (out_valid, out_data, out_partial), and flag flush_pending.
- Reset (reset low, asynchronous): cnt=0, acc=0, out_valid=0, out_data=0, out_partial=0, flush_pending=0.
  - fifo_read_en is forced to 0 combinationally while reset is low.
  - Reset mid-word discards the partial word and any pending flush.
- Output register is "free" when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
- fifo_read_en is combinational and high exactly when all of the following hold:
  - reset is high;
  - fifo_empty is 0;
  - flush_pending is 0;
  - NOT (cnt==RATIO-1 and the output register is not free).
  - This allows a combinational path from out_ready to fifo_read_en.
- Pop at posedge: fifo_read_data is written into lane cnt of acc.
  - If cnt<RATIO-1: cnt increments.
  - If cnt==RATIO-1: the completed word (acc including this lane) loads the output register with out_partial=0; acc clears; cnt wraps to 0.
- Word latency: out_valid rises on the posedge that pops the last lane and is visible in the following cycle.
- Steady-state throughput is one word per RATIO cycles, with no bubble when out_ready stays high.
- Output handshake:
  - out_data and out_partial are held stable while out_valid=1 and out_ready=0.
  - An accept with no new word loaded clears out_valid; out_data keeps its last value.
  - An accept coinciding with a completing pop replaces the word; out_valid stays 1.
- Flush, evaluated at posedge:
  - If flush=1 or flush_pending=1, the effective partial word is acc plus any lane popped this cycle.
  - If the pop completes the word, it is a normal word (out_partial=0) and the flush is consumed.
  - If the effective cnt is 0, flush is a no-op.
  - Otherwise: when the output register is free, load it with the zero-padded partial word, set out_partial=1, clear acc and cnt, clear flush_pending. When it is not free, set flush_pending=1; pops are stalled until the partial word is emitted.
  - flush asserted while flush_pending=1 has no additional effect.
- Only fifo_read_en drives the fifo; the block never pops while fifo_empty=1.

Test Plan:
- Reset with a non-empty fifo: hold reset low for 4 cycles -> fifo_read_en=0, out_valid=0, out_data=0 throughout; no entries are lost from the fifo.
- Streaming (RATIO=2), fifo loaded with 0x00..0x07, out_ready=1 -> words 0x0100, 0x0302, 0x0504, 0x0706 in order, all with out_partial=0; out_valid is first high one cycle after the second pop.
- Backpressure: after word 0x0100 is valid, hold out_ready=0 for 10 cycles ->
  - out_data stays 0x0100;
  - exactly one more entry (0x02) is popped, then fifo_read_en=0;
  - after release, 0x0302 follows on the next word boundary with no loss or duplication.
- Flush: push 0xA1, 0xB2, 0xC3, then pulse flush once the fifo is empty -> 0xB2A1 (partial=0), then 0x00C3 (partial=1); a second flush with cnt=0 produces nothing.
- Flush under stall: with out_ready=0 and one word held, pop 0x11 and pulse flush ->
  - flush_pending holds and fifo_read_en=0 despite further fifo data;
  - on out_ready=1, the held word is accepted, then 0x0011 appears with partial=1;
  - afterwards, packing resumes at lane 0.
- Reset mid-word: pop 0x55, assert reset asynchronously between edges, release, push 0x66, 0x77 -> next word is 0x7766; 0x55 is never emitted.
